// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says sequencer.
// Colour/state encodings, default sizing and the LFSR feedback polynomial.
package simon_pkg;

  typedef logic [1:0] colour_t;

  typedef enum logic [3:0] {
    IDLE,
    APPEND,
    SHOW_RD,
    SHOW_LAT,
    SHOW_ON,
    SHOW_GAP,
    IN_RD,
    IN_WAIT,
    WIN,
    LOSE
  } state_t;

  localparam int         MAX_LEN_DEF   = 11;
  localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;
  // Feedback taps at bits 7, 5, 4 and 3.
  localparam logic [7:0] LFSR_TAPS     = 8'b1011_1000;

  // One spare bit so a sequence length of 16 is still representable.
  localparam int CNT_W = 5;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], ^(l & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/simon_sequencer_if.sv
// Game-facing bundle: player inputs, colour-memory port, LED and status outputs.
// master = sequencer side, slave = player/memory/display side.
interface simon_sequencer_if;
  import simon_pkg::*;

  logic       start;
  logic       btn_valid;
  colour_t    btn_num;
  logic [3:0] mem_address;
  logic       mem_rw;
  colour_t    mem_in_num;
  colour_t    mem_out_num;
  logic       led_valid;
  colour_t    led_num;
  logic [3:0] round;
  logic       busy;
  logic       win;
  logic       lose;

  modport master (
    input  start, btn_valid, btn_num, mem_out_num,
    output mem_address, mem_rw, mem_in_num, led_valid, led_num,
           round, busy, win, lose
  );

  modport slave (
    output start, btn_valid, btn_num, mem_out_num,
    input  mem_address, mem_rw, mem_in_num, led_valid, led_num,
           round, busy, win, lose
  );
endinterface

// File: rtl/simon_lfsr.sv
// 8-bit Fibonacci LFSR colour source; steps only when advance_i is high.
// Colour is the two low bits of the current state.
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
  input  logic    clock,
  input  logic    reset_n,
  input  logic    advance_i,
  output colour_t colour_o
);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (advance_i) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) lfsr_q <= SEED;
    else          lfsr_q <= lfsr_d;
  end

  assign colour_o = lfsr_q[1:0];

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says controller: append a random colour, replay the sequence on the LEDs,
// then check presses against memory. Moore outputs decoded from registered state.
module simon_sequencer
  import simon_pkg::*;
#(
  parameter int         MAX_LEN     = MAX_LEN_DEF,
  parameter int         SHOW_CYCLES = 4,
  parameter int         GAP_CYCLES  = 2,
  parameter logic [7:0] LFSR_SEED   = LFSR_SEED_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  simon_sequencer_if.master  bus
);

  localparam int T_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  state_t        state_q;
  cnt_t          round_q;
  cnt_t          idx_q;
  logic [TW-1:0] timer_q;
  colour_t       led_num_q;
  colour_t       colour;
  logic          idx_last;

  simon_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clock     (clock),
    .reset_n   (reset_n),
    .advance_i (state_q == APPEND),
    .colour_o  (colour)
  );

  assign idx_last = !((idx_q + cnt_t'(1)) < round_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      round_q   <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      led_num_q <= '0;
    end else begin
      case (state_q)
        IDLE, WIN, LOSE: begin
          if (bus.start) begin
            state_q <= APPEND;
            round_q <= '0;
            idx_q   <= '0;
          end
        end
        APPEND: begin
          round_q <= round_q + cnt_t'(1);
          idx_q   <= '0;
          state_q <= SHOW_RD;
        end
        SHOW_RD: state_q <= SHOW_LAT;
        SHOW_LAT: begin
          // Memory data for idx becomes valid in this cycle.
          led_num_q <= bus.mem_out_num;
          timer_q   <= '0;
          state_q   <= SHOW_ON;
        end
        SHOW_ON: begin
          if (timer_q == TW'(SHOW_CYCLES - 1)) begin
            timer_q <= '0;
            state_q <= SHOW_GAP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        SHOW_GAP: begin
          if (timer_q == TW'(GAP_CYCLES - 1)) begin
            timer_q <= '0;
            if (idx_last) begin
              idx_q   <= '0;
              state_q <= IN_RD;
            end else begin
              idx_q   <= idx_q + cnt_t'(1);
              state_q <= SHOW_RD;
            end
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        IN_RD: state_q <= IN_WAIT;
        IN_WAIT: begin
          if (bus.btn_valid) begin
            if (bus.btn_num != bus.mem_out_num) begin
              state_q <= LOSE;
            end else if (!idx_last) begin
              idx_q   <= idx_q + cnt_t'(1);
              state_q <= IN_RD;
            end else if (round_q == cnt_t'(MAX_LEN)) begin
              state_q <= WIN;
            end else begin
              state_q <= APPEND;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_rw      = (state_q == APPEND);
  assign bus.mem_address = (state_q == APPEND) ? round_q[3:0] : idx_q[3:0];
  assign bus.mem_in_num  = (state_q == APPEND) ? colour : '0;
  assign bus.led_valid   = (state_q == SHOW_ON);
  assign bus.led_num     = (state_q == SHOW_ON) ? led_num_q : '0;
  assign bus.round       = round_q[3:0];
  assign bus.busy        = !(state_q inside {IDLE, WIN, LOSE});
  assign bus.win         = (state_q == WIN);
  assign bus.lose        = (state_q == LOSE);

endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer: opening vector table, hand-written reset/lose/win
// sequences, and randomized games scored against a queue-based colour model.
module tb_simon_sequencer;
  import simon_pkg::*;

  localparam int         MAXL = 11;
  localparam int         SHOW = 4;
  localparam int         GAP  = 2;
  localparam logic [7:0] SEED = 8'hA5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  simon_sequencer_if bus();

  simon_sequencer #(
    .MAX_LEN(MAXL), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP), .LFSR_SEED(SEED)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // 2-bit x 16 memory with a registered read port.
  logic [1:0] mem [16];
  logic [1:0] rd_q;
  int         wr11_cnt = 0;
  always @(posedge clock) begin
    if (bus.mem_rw) mem[bus.mem_address] <= bus.mem_in_num;
    rd_q <= mem[bus.mem_address];
    if (bus.mem_rw && bus.mem_address == 4'd11) wr11_cnt <= wr11_cnt + 1;
  end
  assign bus.mem_out_num = rd_q;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: LFSR state and the colours of the current game.
  logic [7:0] m_lfsr;
  logic [1:0] col[$];

  function automatic logic [7:0] lstep(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  function automatic logic [16:0] all_outs();
    return {bus.mem_address, bus.mem_rw, bus.mem_in_num, bus.led_valid, bus.led_num,
            bus.round, bus.busy, bus.win, bus.lose};
  endfunction

  typedef struct {
    logic       st, bv;
    logic [1:0] bn;
    logic       ca, lv;
    logic [1:0] ln;
    logic       rw;
    logic [3:0] ad;
    logic [1:0] dt;
    logic       bsy;
    logic [3:0] rnd;
  } vec_t;

  function automatic vec_t v(logic st, logic bv, logic [1:0] bn, logic ca, logic lv,
                             logic [1:0] ln, logic rw, logic [3:0] ad, logic [1:0] dt,
                             logic bsy, logic [3:0] rnd);
    vec_t r;
    r.st = st; r.bv = bv; r.bn = bn; r.ca = ca; r.lv = lv; r.ln = ln;
    r.rw = rw; r.ad = ad; r.dt = dt; r.bsy = bsy; r.rnd = rnd;
    return r;
  endfunction

  task automatic start_game();
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    col.delete();
  endtask

  // Entered at the negedge where APPEND for length r is visible; leaves at the
  // negedge of whatever follows the last press. bad >= 0 presses a wrong colour there.
  task automatic run_round(input int r, input int bad, input bit noise);
    logic [1:0] c;
    logic [2:0] exp_q[$];
    int errs;
    c = m_lfsr[1:0];
    check($sformatf("append_r%0d", r),
          32'({bus.mem_rw, bus.mem_address, bus.mem_in_num, bus.round, bus.busy}),
          32'({1'b1, 4'(r - 1), c, 4'(r - 1), 1'b1}));
    col.push_back(c);
    m_lfsr = lstep(m_lfsr);
    foreach (col[i]) begin
      repeat (2) exp_q.push_back(3'b000);
      repeat (SHOW) exp_q.push_back({1'b1, col[i]});
      repeat (GAP) exp_q.push_back(3'b000);
    end
    errs = 0;
    foreach (exp_q[k]) begin
      if (noise) begin
        bus.btn_valid = 1'($urandom);
        bus.btn_num   = 2'($urandom);
        bus.start     = 1'($urandom);
      end
      @(negedge clock);
      if ({bus.led_valid, bus.led_num} !== exp_q[k] || bus.mem_rw !== 1'b0 || bus.busy !== 1'b1)
        errs++;
    end
    check($sformatf("playback_r%0d", r), 32'(errs), 32'(0));
    for (int i = 0; i < r; i++) begin
      @(negedge clock);
      bus.btn_valid = 1'b0;
      bus.start     = 1'b0;
      @(negedge clock);
      repeat ($urandom_range(0, 3)) @(negedge clock);
      check($sformatf("wait_r%0d_i%0d", r, i),
            32'({bus.mem_address, bus.round, bus.busy, bus.led_valid, bus.mem_rw}),
            32'({4'(i), 4'(r), 1'b1, 1'b0, 1'b0}));
      bus.btn_valid = 1'b1;
      bus.btn_num   = (i == bad) ? (col[i] ^ 2'b01) : col[i];
      bus.start     = 1'($urandom);
      if (i == bad) break;
    end
    @(negedge clock);
    bus.btn_valid = 1'b0;
    bus.start     = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t tbl[$];

  initial begin
    int n, rr, bi;
    logic [31:0] a, e;

    bus.start = 1'b0; bus.btn_valid = 1'b0; bus.btn_num = 2'b00;
    #1;
    check("reset_outputs", 32'(all_outs()), 32'(0));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    m_lfsr  = SEED;

    // Opening of a game: IDLE, round 1 (colour 01), correct press, round 2 append.
    tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, 0, 1, 1, 0));
    tbl.push_back(v(0, 1, 2, 1, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    for (int k = 0; k < SHOW; k++) tbl.push_back(v(0, 1, 2'(k), 0, 1, 1, 0, 0, 0, 1, 1));
    for (int k = 0; k < GAP; k++)  tbl.push_back(v(0, 1, 3, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0, 1, 0, 0, 1, 1, 2, 1, 1));

    foreach (tbl[k]) begin
      a = 32'({bus.led_valid, tbl[k].lv ? bus.led_num : 2'b00, bus.mem_rw,
               tbl[k].ca ? bus.mem_address : 4'h0, tbl[k].rw ? bus.mem_in_num : 2'b00,
               bus.busy, bus.round, bus.win, bus.lose});
      e = 32'({tbl[k].lv, tbl[k].ln, tbl[k].rw, tbl[k].ca ? tbl[k].ad : 4'h0,
               tbl[k].rw ? tbl[k].dt : 2'b00, tbl[k].bsy, tbl[k].rnd, 2'b00});
      check($sformatf("vec%0d", k), a, e);
      if (k == tbl.size() - 1) break;
      bus.start = tbl[k].st; bus.btn_valid = tbl[k].bv; bus.btn_num = tbl[k].bn;
      @(negedge clock);
    end
    bus.start = 1'b0; bus.btn_valid = 1'b0;

    col.push_back(m_lfsr[1:0]);
    m_lfsr = lstep(m_lfsr);
    run_round(2, -1, 1);
    check("r3_append_const", 32'({bus.mem_rw, bus.mem_address, bus.mem_in_num}),
          32'({1'b1, 4'd2, 2'b01}));

    // Asynchronous reset in the middle of round-3 playback.
    n = 0;
    while (bus.led_valid !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("reach_r3_playback", 32'(bus.led_valid), 32'(1));
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check("midgame_reset_outputs", 32'(all_outs()), 32'(0));
    @(negedge clock);
    reset_n = 1'b1;
    m_lfsr  = SEED;
    @(negedge clock);
    check("idle_after_reset", 32'({bus.busy, bus.round, bus.led_valid}), 32'(0));

    start_game();
    check("reseed_colour", 32'({bus.mem_address, bus.mem_in_num}), 32'({4'd0, 2'b01}));
    run_round(1, -1, 0);
    run_round(2, 1, 0);
    check("lose_r2", 32'({bus.lose, bus.win, bus.busy, bus.round}), 32'({3'b100, 4'd2}));
    repeat (3) begin
      bus.btn_valid = 1'b1; bus.btn_num = 2'($urandom);
      @(negedge clock);
    end
    bus.btn_valid = 1'b0;
    check("lose_hold", 32'({bus.lose, bus.busy, bus.round}), 32'({2'b10, 4'd2}));

    start_game();
    check("restart_round0", 32'({bus.round, bus.mem_address, bus.mem_rw}), 32'({8'd0, 1'b1}));
    for (int r = 1; r <= MAXL; r++) run_round(r, -1, 1);
    check("win_flags", 32'({bus.win, bus.lose, bus.busy, bus.round}), 32'({3'b100, 4'(MAXL)}));
    repeat (4) begin
      bus.btn_valid = 1'b1; bus.btn_num = 2'($urandom);
      @(negedge clock);
    end
    bus.btn_valid = 1'b0;
    check("win_hold", 32'({bus.win, bus.mem_rw, bus.round}), 32'({2'b10, 4'(MAXL)}));
    check("no_write_addr11", 32'(wr11_cnt), 32'(0));

    for (int g = 0; g < 2; g++) begin
      rr = $urandom_range(1, MAXL);
      bi = $urandom_range(0, rr - 1);
      start_game();
      for (int r = 1; r < rr; r++) run_round(r, -1, 1);
      run_round(rr, bi, 1);
      check($sformatf("rand_lose_g%0d", g), 32'({bus.lose, bus.win, bus.busy, bus.round}),
            32'({3'b100, 4'(rr)}));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
